sdram_stream_reader: RTL and testbench

//   Initiator on the sdram front-end user read port (address/read_req/read_ack/data_out).
//   On a start command it fetches LENGTH consecutive 16-bit words from START_ADDR.

---
 rtl/sdram_stream_reader.sv | 171 +++++++++++++++++
 tb/tb_sdram_stream_reader.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_stream_reader.sv
// Streams LENGTH words from the sdram front-end read port
// into a small FIFO exposed as a valid/ready stream.
module sdram_stream_reader #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int LEN_W       = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_req,
  input  logic              mem_read_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_REL,
    FINISH
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              reserved;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [TW-1:0]     tmo;

  logic push;
  logic pop;
  logic slot_free;
  logic tmo_hit;

  // Only one handshake is ever in flight, so the
  // reserved slot is always the one at wr_ptr.
  assign push      = (state == WAIT_ACK) && mem_read_ack;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != '0);
  assign out_data  = fifo_mem[rd_ptr];
  assign slot_free = (count + CW'(reserved))
                     < CW'(FIFO_DEPTH);
  assign tmo_hit   = (tmo == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mem_read_req <= 1'b0;
      mem_address  <= '0;
      addr         <= '0;
      remaining    <= '0;
      reserved     <= 1'b0;
      tmo          <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            addr      <= start_addr;
            remaining <= length;
            err       <= 1'b0;
            busy      <= 1'b1;
            if (length == '0) begin
              state <= FINISH;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (abort) begin
            state <= FINISH;
          end else if (slot_free) begin
            mem_address  <= addr;
            mem_read_req <= 1'b1;
            reserved     <= 1'b1;
            tmo          <= '0;
            state        <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (mem_read_ack) begin
            mem_read_req <= 1'b0;
            reserved     <= 1'b0;
            tmo          <= '0;
            state        <= WAIT_REL;
          end else if (tmo_hit) begin
            mem_read_req <= 1'b0;
            reserved     <= 1'b0;
            err          <= 1'b1;
            state        <= FINISH;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        WAIT_REL: begin
          if (!mem_read_ack) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1) || abort) begin
              state <= FINISH;
            end else begin
              state <= ISSUE;
            end
          end else if (tmo_hit) begin
            err   <= 1'b1;
            state <= FINISH;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_stream_reader.sv
// Bench for sdram_stream_reader: front-end responder model,
// scoreboard of acked data checked against the stream output.
module tb_sdram_stream_reader;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 16;
  localparam int DEPTH  = 8;
  localparam int TMO    = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  length;
  logic              abort;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read_req;
  logic              mem_read_ack;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] addr_q [$];

  int   done_cnt   = 0;
  int   req_hi_cnt = 0;
  int   pop_cnt    = 0;
  int   ack_delay  = 1;
  bit   ack_never  = 1'b0;
  int   dcnt;
  logic prev_req   = 1'b0;

  sdram_stream_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (DEPTH),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_addr  (start_addr),
    .length      (length),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mem_address (mem_address),
    .mem_read_req(mem_read_req),
    .mem_read_ack(mem_read_ack),
    .mem_data    (mem_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] model(
    input logic [ADDR_W-1:0] a
  );
    logic [7:0] hi;
    hi = a[23:16];
    return a[15:0] ^ {hi, hi} ^ 16'h5A3C;
  endfunction

  // Front-end responder: acks ack_delay cycles after req.
  always @(posedge clk) begin
    if (rst) begin
      mem_read_ack <= 1'b0;
      mem_data     <= '0;
      dcnt         <= 0;
    end else if (mem_read_req && !mem_read_ack) begin
      if (!ack_never) begin
        if (dcnt >= ack_delay - 1) begin
          mem_read_ack <= 1'b1;
          mem_data     <= model(mem_address);
          exp_q.push_back(model(mem_address));
          dcnt         <= 0;
        end else begin
          dcnt <= dcnt + 1;
        end
      end
    end else if (!mem_read_req && mem_read_ack) begin
      mem_read_ack <= 1'b0;
      dcnt         <= 0;
    end else if (!mem_read_req) begin
      dcnt <= 0;
    end
  end

  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    if (done) done_cnt++;
    if (mem_read_req) req_hi_cnt++;
    if (mem_read_req && !prev_req)
      addr_q.push_back(mem_address);
    prev_req = mem_read_req;
    if (!rst && out_valid && out_ready) begin
      pop_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h, required no data",
                 out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL stream_data: got %h, required %h",
                   out_data, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(
    input logic [ADDR_W-1:0] a,
    input logic [LEN_W-1:0]  n
  );
    start      = 1'b1;
    start_addr = a;
    length     = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(
    input  string name,
    input  int    budget,
    output int    gaps,
    output logic  busy_at_done
  );
    bit seen;
    seen         = 1'b0;
    gaps         = 0;
    busy_at_done = 1'bx;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen         = 1'b1;
        busy_at_done = busy;
      end else if (!busy) begin
        gaps++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done: none in %0d cycles, required pulse",
               name, budget);
    end
    tick();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: left=%0d valid=%b, required 0 0",
               name, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    start_addr = '0;
    length     = '0;
    repeat (3) tick();
    checks += 6;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b, required 0", done);
    end
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b, required 0", err);
    end
    if (mem_read_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: got %b, required 0", mem_read_req);
    end
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b, required 0", out_valid);
    end
    if (mem_address !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %h, required 0", mem_address);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int                gaps;
    logic              bd;
    logic [ADDR_W-1:0] ea;
    out_ready = 1'b1;
    ack_delay = 1;
    addr_q.delete();
    done_cnt = 0;
    start_xfer(24'h000100, 16'd4);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b, required 1", busy);
    end
    wait_done("basic", 200, gaps, bd);
    checks += 2;
    if (gaps != 0) begin
      errors++;
      $display("FAIL basic_busy_gap: got %0d, required 0", gaps);
    end
    if (bd !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done: got %b, required 0", bd);
    end
    repeat (3) tick();
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done_cnt: got %0d, required 1", done_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      ea = 24'h000100 + ADDR_W'(i);
      checks++;
      if (addr_q.size() <= i || addr_q[i] !== ea) begin
        errors++;
        $display("FAIL basic_addr%0d: got %h, required %h", i,
                 (addr_q.size() > i) ? addr_q[i] : 'x, ea);
      end
    end
    drain("basic");
  endtask

  task automatic test_backpressure;
    int   gaps;
    logic bd;
    out_ready = 1'b0;
    ack_delay = 1;
    addr_q.delete();
    start_xfer(24'h002000, 16'd20);
    repeat (50) tick();
    checks += 3;
    if (addr_q.size() != DEPTH) begin
      errors++;
      $display("FAIL bp_handshakes: got %0d, required %0d",
               addr_q.size(), DEPTH);
    end
    if (mem_read_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_req_low: got %b, required 0", mem_read_req);
    end
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid: got %b, required 1", out_valid);
    end
    out_ready = 1'b1;
    wait_done("bp", 600, gaps, bd);
    checks += 2;
    if (addr_q.size() != 20) begin
      errors++;
      $display("FAIL bp_total: got %0d, required 20", addr_q.size());
    end
    if (addr_q.size() < 20 || addr_q[19] !== 24'h002013) begin
      errors++;
      $display("FAIL bp_last_addr: got %h, required 002013",
               (addr_q.size() >= 20) ? addr_q[19] : 'x);
    end
    drain("bp");
  endtask

  task automatic test_wrap_zero;
    int                gaps;
    logic              bd;
    logic [ADDR_W-1:0] ea;
    out_ready = 1'b1;
    ack_delay = 2;
    addr_q.delete();
    start_xfer(24'hFFFFFE, 16'd4);
    wait_done("wrap", 200, gaps, bd);
    for (int i = 0; i < 4; i++) begin
      ea = 24'hFFFFFE;
      ea = ea + ADDR_W'(i);
      checks++;
      if (addr_q.size() <= i || addr_q[i] !== ea) begin
        errors++;
        $display("FAIL wrap_addr%0d: got %h, required %h", i,
                 (addr_q.size() > i) ? addr_q[i] : 'x, ea);
      end
    end
    drain("wrap");
    addr_q.delete();
    done_cnt = 0;
    start_xfer(24'h000123, 16'd0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_first: busy=%b done=%b, required 1 0",
               busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: busy=%b done=%b, required 0 1",
               busy, done);
    end
    repeat (3) tick();
    checks++;
    if (addr_q.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_noreq: reqs=%0d dones=%0d, required 0 1",
               addr_q.size(), done_cnt);
    end
  endtask

  task automatic test_abort;
    int   gaps;
    int   early;
    logic bd;
    out_ready = 1'b1;
    ack_delay = 5;
    addr_q.delete();
    pop_cnt = 0;
    start_xfer(24'h000300, 16'd10);
    for (int i = 0; i < 20 && !mem_read_req; i++) tick();
    abort = 1'b1;
    early = 0;
    for (int i = 0; i < 20 && !mem_read_ack; i++) begin
      if (!mem_read_req) early++;
      tick();
    end
    checks++;
    if (early != 0 || mem_read_ack !== 1'b1) begin
      errors++;
      $display("FAIL abort_req_hold: drops=%0d ack=%b, required 0 1",
               early, mem_read_ack);
    end
    wait_done("abort", 100, gaps, bd);
    abort = 1'b0;
    repeat (10) tick();
    drain("abort");
    checks += 3;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL abort_err: got %b, required 0", err);
    end
    if (pop_cnt != 1) begin
      errors++;
      $display("FAIL abort_words: got %0d, required 1", pop_cnt);
    end
    if (addr_q.size() != 1) begin
      errors++;
      $display("FAIL abort_reqs: got %0d, required 1", addr_q.size());
    end
  endtask

  task automatic test_timeout;
    int   gaps;
    logic bd;
    out_ready  = 1'b1;
    ack_never  = 1'b1;
    addr_q.delete();
    req_hi_cnt = 0;
    start_xfer(24'h000400, 16'd3);
    wait_done("tmo", 100, gaps, bd);
    checks += 4;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_err: got %b, required 1", err);
    end
    if (req_hi_cnt != TMO) begin
      errors++;
      $display("FAIL tmo_req_cycles: got %0d, required %0d",
               req_hi_cnt, TMO);
    end
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_valid: got %b, required 0", out_valid);
    end
    if (addr_q.size() != 1) begin
      errors++;
      $display("FAIL tmo_reqs: got %0d, required 1", addr_q.size());
    end
    ack_never = 1'b0;
    ack_delay = 1;
    start_xfer(24'h000410, 16'd1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err_clear: got %b, required 0", err);
    end
    wait_done("tmo_next", 100, gaps, bd);
    drain("tmo_next");
  endtask

  task automatic test_reset_mid;
    int   gaps;
    logic bd;
    bit   hit;
    out_ready = 1'b0;
    ack_delay = 3;
    addr_q.delete();
    start_xfer(24'h000600, 16'd4);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      tick();
      hit = (addr_q.size() >= 2) && mem_read_req
            && !mem_read_ack;
    end
    checks++;
    if (!hit || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup: hit=%b valid=%b, required 1 1",
               hit, out_valid);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (mem_read_req !== 1'b0 || busy !== 1'b0
        || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: req=%b busy=%b valid=%b, required 0 0 0",
               mem_read_req, busy, out_valid);
    end
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    out_ready = 1'b1;
    ack_delay = 1;
    tick();
    start_xfer(24'h000700, 16'd2);
    wait_done("rstmid", 100, gaps, bd);
    checks += 2;
    if (addr_q.size() != 2 || addr_q[0] !== 24'h000700) begin
      errors++;
      $display("FAIL rstmid_restart: reqs=%0d, required 2 from 000700",
               addr_q.size());
    end
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_err: got %b, required 0", err);
    end
    drain("rstmid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_zero();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
